flash_sample_reader: RTL and testbench

Downstream consumer of the playback address counter. Reads one 32-bit word from the flash controller at the current word address and splits it into two signed 16-bit audio samples. Presents one sample per sample_tick, then pulses advance, which the address counter uses as its change input. Sits between the address counter and the audio output path.

---
 rtl/flash_sample_reader_if.sv | 27 ++
 rtl/flash_sample_reader.sv | 154 +++++++++++++++
 tb/tb_flash_sample_reader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_sample_reader_if.sv
// Flash controller read port (Avalon-MM style, read only) between the sample reader and the flash controller.
// master: the reader, which issues requests; slave: the flash controller.
interface flash_sample_reader_if #(
    parameter int ADDR_W = 23
);
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word per address step and plays it out as two signed 16-bit samples.
// Optional macro READ_TIMEOUT_EN: reissue the read if readdatavalid is missing for TIMEOUT_CYCLES cycles.
module flash_sample_reader #(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  forward,
    input  logic                  sample_tick,
    input  logic [ADDR_W-1:0]     address,
    flash_sample_reader_if.master flash,
    output logic [15:0]           audio_sample,
    output logic                  sample_valid,
    output logic                  advance
);

    // state     | meaning
    // IDLE      | paused, no word held
    // REQ       | flash_read asserted until the controller accepts
    // WAIT_DATA | request accepted, waiting for readdatavalid
    // FIRST     | word held, waiting for the tick that plays the first half
    // SECOND    | waiting for the tick that plays the second half
    // ADVANCE   | one-cycle advance pulse to the address counter
    // SETTLE    | one cycle for the address counter to update
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        FIRST,
        SECOND,
        ADVANCE,
        SETTLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              order_q, order_d;
    logic [15:0]       sample_q, sample_d;
    logic              sample_valid_q, sample_valid_d;
    logic              read_q, read_d;
    logic              advance_q, advance_d;

`ifdef READ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        word_d         = word_q;
        order_d        = order_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
`ifdef READ_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = REQ;
                    addr_d  = address;
                end
            end
            REQ: begin
                if (!flash.flash_waitrequest) begin
                    state_d = WAIT_DATA;
`ifdef READ_TIMEOUT_EN
                    tmo_d   = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            WAIT_DATA: begin
                // half order is frozen here so a later forward change only affects the next word
                if (flash.flash_readdatavalid) begin
                    state_d = FIRST;
                    word_d  = flash.flash_readdata;
                    order_d = forward;
                end
`ifdef READ_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    state_d = REQ;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end
            FIRST: begin
                if (enable && sample_tick) begin
                    state_d        = SECOND;
                    sample_d       = order_q ? word_q[15:0] : word_q[31:16];
                    sample_valid_d = 1'b1;
                end
            end
            SECOND: begin
                if (enable && sample_tick) begin
                    state_d        = ADVANCE;
                    sample_d       = order_q ? word_q[31:16] : word_q[15:0];
                    sample_valid_d = 1'b1;
                end
            end
            ADVANCE: state_d = SETTLE;
            SETTLE: begin
                if (enable) begin
                    state_d = REQ;
                    addr_d  = address;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        read_d    = (state_d == REQ);
        advance_d = (state_d == ADVANCE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            word_q         <= '0;
            order_q        <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            read_q         <= 1'b0;
            advance_q      <= 1'b0;
`ifdef READ_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            word_q         <= word_d;
            order_q        <= order_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            read_q         <= read_d;
            advance_q      <= advance_d;
`ifdef READ_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign flash.flash_read    = read_q;
    assign flash.flash_address = addr_q;
    assign audio_sample        = sample_q;
    assign sample_valid        = sample_valid_q;
    assign advance             = advance_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: directed scenarios followed by random playback, checked against
// a behavioural flash/address-counter model and an expected-sample queue.
`timescale 1ns/1ps
module tb_flash_sample_reader;
    localparam int ADDR_W = 23;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              forward = 1'b1;
    logic              sample_tick = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [15:0]       audio_sample;
    logic              sample_valid;
    logic              advance;

    always #5 clk = ~clk;

    flash_sample_reader_if #(.ADDR_W(ADDR_W)) fif ();

    flash_sample_reader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .forward      (forward),
        .sample_tick  (sample_tick),
        .address      (address),
        .flash        (fif),
        .audio_sample (audio_sample),
        .sample_valid (sample_valid),
        .advance      (advance)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // model of the address counter, the flash contents and the expected playback
    logic [ADDR_W-1:0] addr_tb = '0;
    logic [15:0]       exp_q[$];
    logic [15:0]       last_audio = '0;
    logic [15:0]       salt;
    logic [31:0]       fixed_word = '0;
    bit                use_fixed = 0, no_resp = 0, late_valid = 0;
    int                since_adv = 0, outstanding = 0, lat = 0;
    int                lat_min = 1, lat_max = 4, wr_pct = 0, spur_pct = 0, wr_hold = 0;
    int                n_acc = 0, n_rd = 0, n_sv = 0, n_adv = 0, cyc = 0, acc_cyc = 0, rise_cyc = 0;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ salt, a[22:7] + salt};
    endfunction

    // one clock: drive inputs, let the edge pass, then compare outputs with the model
    task automatic cycle(input bit en, input bit tk);
        bit          wr, acc, tkn, rd_before, rst_now;
        logic [31:0] w;
        enable      = en;
        sample_tick = tk;
        address     = addr_tb;
        if (wr_hold > 0) begin
            wr = 1'b1;
            wr_hold--;
        end else begin
            wr = ($urandom_range(0, 99) < wr_pct);
        end
        fif.flash_waitrequest   = wr;
        fif.flash_readdatavalid = 1'b0;
        fif.flash_readdata      = $urandom;
        if (outstanding != 0 && !rst) begin
            lat--;
            if (lat == 0) begin
                w = use_fixed ? fixed_word : mem_word(addr_tb);
                fif.flash_readdata      = w;
                fif.flash_readdatavalid = 1'b1;
                outstanding = 0;
                if (forward) begin
                    exp_q.push_back(w[15:0]);
                    exp_q.push_back(w[31:16]);
                end else begin
                    exp_q.push_back(w[31:16]);
                    exp_q.push_back(w[15:0]);
                end
            end
        end else if (late_valid || ($urandom_range(0, 99) < spur_pct)) begin
            fif.flash_readdatavalid = 1'b1;
        end
        acc       = (fif.flash_read === 1'b1) && !wr && !rst;
        tkn       = tk && en;
        rd_before = (fif.flash_read === 1'b1);
        rst_now   = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_now) begin
            outstanding = 0;
            exp_q.delete();
            since_adv  = 0;
            last_audio = '0;
        end
        if (acc) begin
            n_acc++;
            acc_cyc = cyc;
            check("req_addr", 32'(fif.flash_address), 32'(addr_tb));
            if (!no_resp) begin
                outstanding = 1;
                lat = $urandom_range(lat_min, lat_max);
            end
        end
        if (fif.flash_read === 1'b1) begin
            n_rd++;
            check("req_addr_stable", 32'(fif.flash_address), 32'(addr_tb));
            if (!rd_before) rise_cyc = cyc;
        end
        if (sample_valid === 1'b1) begin
            n_sv++;
            check("tick_before_sample", 32'(tkn), 1);
            check("samples_per_word_max", 32'(since_adv < 2), 1);
            since_adv++;
            if (exp_q.size() == 0) check("sample_expected", 0, 1);
            else check("audio_sample", 32'(audio_sample), 32'(exp_q.pop_front()));
        end else begin
            check("audio_hold", 32'(audio_sample), 32'(last_audio));
        end
        if (advance === 1'b1) begin
            n_adv++;
            check("samples_per_word", 32'(since_adv), 2);
            since_adv = 0;
            addr_tb = forward ? addr_tb + 1'b1 : addr_tb - 1'b1;
        end
        last_audio = audio_sample;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_read"},    32'(fif.flash_read),    0);
        check({tag, "_address"}, 32'(fif.flash_address), 0);
        check({tag, "_audio"},   32'(audio_sample),      0);
        check({tag, "_valid"},   32'(sample_valid),      0);
        check({tag, "_advance"}, 32'(advance),           0);
    endtask

    initial begin
        int          a0, r0, d0, v0, first_acc;
        logic [15:0] hold;
        bit          en_r, fwd_r, tk_r;
        salt = 16'($urandom);
        fif.flash_waitrequest   = 1'b0;
        fif.flash_readdata      = '0;
        fif.flash_readdatavalid = 1'b0;

        rst = 1'b1;
        cycle(0, 0);
        cycle(0, 0);
        rst = 1'b0;
        check_idle("reset");

        // forward word: low half first
        use_fixed = 1; fixed_word = 32'hAAAA5555; addr_tb = 23'h000010; forward = 1'b1;
        wr_pct = 0; lat_min = 3; lat_max = 3;
        a0 = n_acc; r0 = n_rd; v0 = n_sv;
        repeat (8) cycle(1, 0);
        check("t1_accepts", 32'(n_acc - a0), 1);
        check("t1_read_cycles", 32'(n_rd - r0), 1);
        cycle(1, 1);
        check("t1_tick1", 32'(audio_sample), 32'h5555);
        cycle(1, 0);
        d0 = n_adv;
        cycle(1, 1);
        check("t1_tick2", 32'(audio_sample), 32'hAAAA);
        check("t1_samples", 32'(n_sv - v0), 2);
        repeat (4) cycle(0, 0);
        check("t1_advance", 32'(n_adv - d0), 1);

        // reverse word: high half first
        forward = 1'b0;
        repeat (8) cycle(1, 0);
        cycle(1, 1);
        check("t2_tick1", 32'(audio_sample), 32'hAAAA);
        cycle(1, 0);
        d0 = n_adv;
        cycle(1, 1);
        check("t2_tick2", 32'(audio_sample), 32'h5555);
        repeat (4) cycle(0, 0);
        check("t2_advance", 32'(n_adv - d0), 1);

        // controller stalls the request for five cycles
        wr_hold = 6; a0 = n_acc; r0 = n_rd; v0 = n_sv;
        repeat (10) cycle(1, 0);
        check("t3_accepts", 32'(n_acc - a0), 1);
        check("t3_read_cycles", 32'(n_rd - r0), 6);
        cycle(1, 1);
        cycle(1, 1);
        check("t3_samples", 32'(n_sv - v0), 2);
        repeat (4) cycle(0, 0);

        // pause while a word is held
        forward = 1'b1; fixed_word = 32'h1234ABCD;
        repeat (8) cycle(1, 0);
        v0 = n_sv; hold = audio_sample;
        repeat (4) begin
            cycle(0, 1);
            cycle(0, 0);
        end
        check("t4_pause_valid", 32'(n_sv - v0), 0);
        check("t4_pause_hold", 32'(audio_sample), 32'(hold));
        cycle(1, 1);
        check("t4_resume_valid", 32'(n_sv - v0), 1);
        check("t4_resume_first", 32'(audio_sample), 32'hABCD);
        cycle(1, 1);
        repeat (4) cycle(0, 0);

        // tick arriving while the read is still outstanding is dropped
        forward = 1'b0; fixed_word = 32'hC0DEBEEF; lat_min = 4; lat_max = 4;
        cycle(1, 0);
        cycle(1, 0);
        v0 = n_sv; hold = audio_sample;
        cycle(1, 1);
        check("t5_underrun_valid", 32'(n_sv - v0), 0);
        check("t5_underrun_hold", 32'(audio_sample), 32'(hold));
        repeat (5) cycle(1, 0);
        cycle(1, 1);
        check("t5_first", 32'(audio_sample), 32'hC0DE);
        cycle(1, 1);
        repeat (4) cycle(0, 0);

        // read that never returns
        lat_min = 1; lat_max = 4; no_resp = 1;
        a0 = n_acc; r0 = n_rd;
        cycle(1, 0);
        cycle(1, 0);
        first_acc = acc_cyc;
        rise_cyc  = 0;
`ifdef READ_TIMEOUT_EN
        repeat (TMO + 2) cycle(1, 0);
        check("t6_reissue_delay", 32'(rise_cyc - first_acc), TMO);
        check("t6_reissue_count", 32'(n_acc - a0), 2);
`else
        repeat (50) cycle(1, 0);
        check("t6_no_reissue", 32'(n_acc - a0), 1);
        check("t6_read_cycles", 32'(n_rd - r0), 1);
        check("t6_no_rise", 32'(rise_cyc), 0);
`endif

        // reset while waiting for data, then a stale readdatavalid
        rst = 1'b1;
        cycle(0, 0);
        rst = 1'b0;
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        rst = 1'b1;
        cycle(1, 0);
        rst = 1'b0;
        check_idle("t7_rst");
        late_valid = 1;
        cycle(0, 0);
        late_valid = 0; no_resp = 0;
        v0 = n_sv;
        cycle(1, 1);
        check("t7_late_valid_ignored", 32'(n_sv - v0), 0);

        // random playback
        use_fixed = 0; wr_pct = 30; spur_pct = 10;
        d0 = n_adv; v0 = n_sv; fwd_r = forward;
        for (int i = 0; i < 4000; i++) begin
            en_r = ($urandom_range(0, 99) < 85);
            tk_r = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 99) < 2) fwd_r = !fwd_r;
            forward = fwd_r;
            cycle(en_r, tk_r);
        end
        check("rand_progress", 32'((n_adv - d0) > 100), 1);
        check("rand_sample_count",
              32'(((n_sv - v0) - 2 * (n_adv - d0)) >= 0 && ((n_sv - v0) - 2 * (n_adv - d0)) <= 2), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
